// File: rtl/gate_2_pkg.sv
// Shared constants for the gate_2 block: result bus width, bit positions and reset value.
package gate_2_pkg;

   localparam int unsigned Z_W = 6;

   localparam int unsigned Z_AND  = 0;
   localparam int unsigned Z_NAND = 1;
   localparam int unsigned Z_OR   = 2;
   localparam int unsigned Z_NOR  = 3;
   localparam int unsigned Z_XOR  = 4;
   localparam int unsigned Z_XNOR = 5;

   // Not the a=b=0 truth value, so a cleared register is distinguishable from live data.
   localparam logic [Z_W-1:0] Z_RESET = 6'b000000;

endpackage

// File: rtl/gate_2_cell.sv
// Combinational core: the six two-input Boolean functions of a and b, unregistered.
module gate_2_cell
   import gate_2_pkg::*;
(
   input  logic           a,
   input  logic           b,
   output logic [Z_W-1:0] z
);

   always_comb begin
      z         = '0;
      z[Z_AND]  = a & b;
      z[Z_NAND] = ~(a & b);
      z[Z_OR]   = a | b;
      z[Z_NOR]  = ~(a | b);
      z[Z_XOR]  = a ^ b;
      z[Z_XNOR] = ~(a ^ b);
   end

endmodule

// File: rtl/gate_2.sv
// Registered gate reference: loads the gate_2_cell results every edge, synchronous reset wins.
module gate_2
   import gate_2_pkg::*;
(
   input  logic           clk,
   input  logic           reset,
   input  logic           a,
   input  logic           b,
   output logic [Z_W-1:0] z
);

   logic [Z_W-1:0] cell_z;
   logic [Z_W-1:0] z_d;
   logic [Z_W-1:0] z_q;

   gate_2_cell u_cell (
      .a (a),
      .b (b),
      .z (cell_z)
   );

   always_comb begin
      z_d = cell_z;
      if (reset) begin
         z_d = Z_RESET;
      end
   end

   always_ff @(posedge clk) begin
      z_q <= z_d;
   end

   assign z = z_q;

endmodule

// File: tb/tb_gate_2.sv
// Scoreboard bench for gate_2: stimulus pushes hand-computed results, a monitor pops and checks.
module tb_gate_2;

   logic       clk;
   logic       reset;
   logic       a;
   logic       b;
   logic [5:0] z;

   logic [5:0] exp_q[$];
   int         n_checks;
   int         n_pass;

   gate_2 dut (
      .clk   (clk),
      .reset (reset),
      .a     (a),
      .b     (b),
      .z     (z)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [5:0] got, input logic [5:0] want);
      n_checks++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got %b, required %b at %0t", name, got, want, $time);
   endtask

   // Drive inputs away from the edge, then record what the edge should load.
   task automatic step(input logic r, input logic ai, input logic bi, input logic [5:0] want,
                       input bit glitch);
      @(negedge clk);
      reset = r;
      a     = ai;
      b     = bi;
      @(posedge clk);
      exp_q.push_back(want);
      if (glitch) begin
         #3 a = ~a;
         #1 check("mid_cycle_hold", z, want);
         b = ~b;
         #0.5 check("mid_cycle_hold_b", z, want);
      end
   endtask

   // Monitor: the output is presented every cycle, one edge after the stimulus.
   initial begin
      logic [5:0] want;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            check("z", z, want);
            if (want != 6'b000000) begin
               check("pair_nand", {5'b0, z[1]}, {5'b0, ~z[0]});
               check("pair_nor",  {5'b0, z[3]}, {5'b0, ~z[2]});
               check("pair_xnor", {5'b0, z[5]}, {5'b0, ~z[4]});
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL timeout: got no finish, required finish before 100000");
      $fatal(1);
   end

   initial begin
      n_checks = 0;
      n_pass   = 0;
      reset    = 1'b1;
      a        = 1'b1;
      b        = 1'b1;

      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 6'b000000, 1'b0);
      step(1'b0, 1'b0, 1'b0, 6'b101010, 1'b0);
      step(1'b0, 1'b1, 1'b0, 6'b010110, 1'b0);
      step(1'b0, 1'b0, 1'b1, 6'b010110, 1'b0);
      step(1'b0, 1'b1, 1'b1, 6'b100101, 1'b0);
      step(1'b1, 1'b1, 1'b1, 6'b000000, 1'b0);
      step(1'b0, 1'b1, 1'b1, 6'b100101, 1'b0);
      step(1'b0, 1'b0, 1'b0, 6'b101010, 1'b1);
      step(1'b0, 1'b1, 1'b0, 6'b010110, 1'b1);
      step(1'b1, 1'b0, 1'b0, 6'b000000, 1'b0);
      step(1'b1, 1'b1, 1'b0, 6'b000000, 1'b0);
      step(1'b0, 1'b1, 1'b1, 6'b100101, 1'b0);

      repeat (2) @(posedge clk);
      #2;
      check("scoreboard_drained", 6'(exp_q.size()), 6'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
